mem_access_stage: RTL and testbench

MEM pipeline stage plus MEM/WB register. Consumes the EX/MEM register outputs (control, ALU result, store data, destination register), runs a multi-cycle request/ready handshake to the data memory for loads and stores, and asserts `Stall_o` to freeze the upstream pipeline, including the EX/MEM `Stall_i`, until the access completes. Its registered outputs feed the register-file write port.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/MEM_WB.sv | 34 +++
 rtl/mem_access_stage.sv | 111 +++++++++++
 tb/tb_mem_access_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions and MEM-stage FSM encoding.
package pipe_pkg;

    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/MEM_WB.sv
// MEM/WB pipeline register; a bubble loads an all-zero (no write) entry.
// Latency: 1 cycle.
// Backpressure: none; loads every cycle, bubble takes priority over data.
module MEM_WB #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bubble,
    input  logic              reg_write,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              RegWrite_o,
    output logic [4:0]        RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else if (bubble) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else begin
            RegWrite_o <= reg_write;
            RDaddr_o   <= rd_addr;
            RDdata_o   <= rd_data;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs a req/ready data-memory access for loads/stores and feeds MEM/WB.
// Latency: 1 cycle for non-memory ops; k+2 cycles for a memory op with ready after k.
// Backpressure: Stall_o freezes upstream from issue until the ready cycle (k+1 cycles).
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        ctrl_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [4:0]        RDaddr_i,
    output logic              Stall_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              RegWrite_o,
    output logic [4:0]        RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              access;
    logic              stall;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_data;

    assign access = ctrl_i[CTRL_MEMREAD] | ctrl_i[CTRL_MEMWRITE];

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Upstream sees no stall while held in reset.
    assign Stall_o = stall & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory port registers stay stable for the whole ACCESS phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
        end else if (state_q == IDLE && access) begin
            mem_req_o   <= 1'b1;
            mem_wen_o   <= ctrl_i[CTRL_MEMWRITE];
            mem_addr_o  <= ALUResult_i[ADDR_W+1:2];
            mem_wdata_o <= RS2data_i;
        end else if (state_q == ACCESS && mem_ready_i) begin
            mem_req_o <= 1'b0;
            rdata_q   <= mem_rdata_i;
        end
    end

    // Read data is only meaningful once an access has completed (DONE).
    assign wb_reg_write = ctrl_i[CTRL_REGWRITE] & (RDaddr_i != 5'd0);
    assign wb_data      = (state_q == DONE && ctrl_i[CTRL_MEMTOREG]) ? rdata_q
                                                                     : ALUResult_i[DATA_W-1:0];

    MEM_WB #(
        .DATA_W (DATA_W)
    ) u_mem_wb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bubble     (stall),
        .reg_write  (wb_reg_write),
        .rd_addr    (RDaddr_i),
        .rd_data    (wb_data),
        .RegWrite_o (RegWrite_o),
        .RDaddr_o   (RDaddr_o),
        .RDdata_o   (RDdata_o)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: per-instruction expected write-back records
// are queued at issue and compared after the retire edge.
module tb_mem_access_stage;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk_i;
    logic              rst_i;
    logic [3:0]        ctrl_i;
    logic [31:0]       ALUResult_i;
    logic [DATA_W-1:0] RS2data_i;
    logic [4:0]        RDaddr_i;
    logic              Stall_o;
    logic              mem_req_o;
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    logic              RegWrite_o;
    logic [4:0]        RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_access_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ctrl_i      (ctrl_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .RDaddr_i    (RDaddr_i),
        .Stall_o     (Stall_o),
        .mem_req_o   (mem_req_o),
        .mem_wen_o   (mem_wen_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .RegWrite_o  (RegWrite_o),
        .RDaddr_o    (RDaddr_o),
        .RDdata_o    (RDdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_we"}, RegWrite_o, 1'b0);
        check({tag, "_rd"}, RDaddr_o, 5'd0);
        check({tag, "_dat"}, RDdata_o, 32'd0);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_we"}, RegWrite_o, e.we);
            check({tag, "_rd"}, RDaddr_o, e.rd);
            check({tag, "_dat"}, RDdata_o, e.dat);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the retire edge's outputs are checked.
    task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input int k,
                         input logic [31:0] rdata, input logic stray);
        exp_t e;
        logic is_mem;
        int   stalls;
        is_mem = ctrl[1] | ctrl[0];
        e.we   = ctrl[3] && (rd != 5'd0);
        e.rd   = rd;
        e.dat  = (is_mem && ctrl[2]) ? rdata : alu;
        sb.push_back(e);

        ctrl_i      = ctrl;
        ALUResult_i = alu;
        RS2data_i   = rs2;
        RDaddr_i    = rd;
        mem_ready_i = stray;
        mem_rdata_i = 32'h0BAD_0000;
        stalls      = 0;

        @(negedge clk_i);
        check({tag, "_issue_stall"}, Stall_o, is_mem);
        check({tag, "_issue_req"}, mem_req_o, 1'b0);
        if (Stall_o) stalls++;

        if (is_mem) begin
            for (int i = 1; i <= k; i++) begin
                @(posedge clk_i); #1;
                mem_ready_i = (i == k);
                mem_rdata_i = (i == k) ? rdata : (32'h0BAD_0000 + i);
                @(negedge clk_i);
                check({tag, "_acc_req"}, mem_req_o, 1'b1);
                check({tag, "_acc_stall"}, Stall_o, 1'b1);
                check({tag, "_acc_addr"}, mem_addr_o, alu[31:2]);
                check({tag, "_acc_wen"}, mem_wen_o, ctrl[0]);
                check({tag, "_acc_wdata"}, mem_wdata_o, rs2);
                check_bubble({tag, "_acc_bub"});
                if (Stall_o) stalls++;
            end
            @(posedge clk_i); #1;
            mem_ready_i = 1'b0;
            mem_rdata_i = 32'h0BAD_FFFF;
            @(negedge clk_i);
            check({tag, "_done_stall"}, Stall_o, 1'b0);
            check({tag, "_done_req"}, mem_req_o, 1'b0);
            check_bubble({tag, "_done_bub"});
            check({tag, "_stall_cycles"}, stalls, k + 1);
        end

        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        pop_compare(tag);
    endtask

    initial begin
        rst_i       = 1'b1;
        ctrl_i      = 4'b0000;
        ALUResult_i = 32'd0;
        RS2data_i   = '0;
        RDaddr_i    = 5'd0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;

        #1;
        check("rst_req", mem_req_o, 1'b0);
        check("rst_stall", Stall_o, 1'b0);
        check("rst_addr", mem_addr_o, '0);
        check_bubble("rst_wb");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        do_op("alu",      4'b1000, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 1'b0);
        do_op("x0",       4'b1000, 32'h0000_0055, 32'h0, 5'd0, 0, 32'h0, 1'b0);
        do_op("load_k3",  4'b1110, 32'h0000_0108, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 1'b0);
        check("load_k3_addr42", mem_addr_o, 30'h42);
        do_op("store_k1", 4'b0001, 32'h0000_0200, 32'hA5A5_A5A5, 5'd3, 1, 32'h1111_2222, 1'b0);
        do_op("ldst_both", 4'b1111, 32'h0000_0A04, 32'h5A5A_0F0F, 5'd9, 2, 32'hCAFE_F00D, 1'b0);

        // Stray ready during an IDLE cycle, then back-to-back loads.
        do_op("stray_alu", 4'b1000, 32'h0000_0777, 32'h0, 5'd12, 0, 32'h0, 1'b1);
        do_op("b2b_ld1",  4'b1110, 32'h0000_0010, 32'h0, 5'd10, 2, 32'h1357_9BDF, 1'b1);
        do_op("b2b_ld2",  4'b1110, 32'h0000_0014, 32'h0, 5'd11, 1, 32'h2468_ACE0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [4:0]  r;
            a = $urandom;
            r = 5'($urandom_range(0, 31));
            do_op("rand_alu", {1'b1, 3'b000}, a, 32'h0, r, 0, 32'h0, 1'b0);
        end

        // Reset in the middle of an access.
        ctrl_i      = 4'b1110;
        ALUResult_i = 32'h0000_0300;
        RDaddr_i    = 5'd4;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_pre_req", mem_req_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("midrst_req", mem_req_o, 1'b0);
        check("midrst_wen", mem_wen_o, 1'b0);
        check("midrst_addr", mem_addr_o, '0);
        check("midrst_wdata", mem_wdata_o, '0);
        check("midrst_stall", Stall_o, 1'b0);
        check_bubble("midrst_wb");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        do_op("post_rst_alu", 4'b1000, 32'h0000_0077, 32'h0, 5'd2, 0, 32'h0, 1'b0);
        @(negedge clk_i);
        check("post_rst_no_retry", mem_req_o, 1'b0);

        ctrl_i = 4'b0000;
        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
